hash_result_scan: RTL

HASH_RESULT_SCAN -- requirements
Module: hash_result_scan

---
 rtl/hash_result_scan.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/hash_result_scan.sv
// hash_result_scan
//   Walks the hash results of NUM_NONCES nonces held in memory, keeps the
//   numerically smallest 256-bit hash, and reports its nonce index, its
//   word 0, and whether that word is below the caller's target.
//
//   Memory layout: word i (0..7) of nonce n lives at
//   output_addr + NUM_NONCES*i + n (16-bit wrap-around).
//   Word 0 is the most significant word of the hash.
//
// Ports
//   clk            : sole clock, rising edge
//   reset          : synchronous, active-high
//   start          : begin a scan (only honoured while idle)
//   output_addr    : base address of the result region, latched on start
//   target         : threshold for word 0 of the best hash, latched on start
//   done           : one-cycle pulse when best_* / found are valid
//   mem_clk        : copy of clk for the memory
//   mem_we         : always 0 (read-only initiator)
//   mem_addr       : read address (0 when not reading)
//   mem_write_data : always 0
//   mem_read_data  : read data, valid the cycle after its address
//   best_nonce     : index of the smallest hash
//   best_h0        : word 0 of the smallest hash
//   found          : best_h0 < target (unsigned)
module hash_result_scan #(
  parameter int NUM_NONCES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [15:0]                   output_addr,
  input  logic [31:0]                   target,
  output logic                          done,
  output logic                          mem_clk,
  output logic                          mem_we,
  output logic [15:0]                   mem_addr,
  output logic [31:0]                   mem_write_data,
  input  logic [31:0]                   mem_read_data,
  output logic [$clog2(NUM_NONCES)-1:0] best_nonce,
  output logic [31:0]                   best_h0,
  output logic                          found
);

  localparam int NONCE_W = $clog2(NUM_NONCES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [NONCE_W-1:0]   n_cnt;
  logic [3:0]           c_cnt;
  logic [15:0]          base_addr;
  logic [31:0]          target_q;
  logic [31:0]          cand_w [8];
  logic [255:0]         cand_hash;
  logic [255:0]         best_hash;
  logic [NONCE_W-1:0]   best_idx;

  logic [15:0]          word_off;
  logic [2:0]           cap_word;
  logic                 last_nonce;
  logic                 take_cand;
  logic [255:0]         best_hash_nxt;
  logic [NONCE_W-1:0]   best_idx_nxt;

  // Unsigned 256-bit ordering; word 0 sits in the top bits of the vector.
  function automatic logic hash_lt(input logic [255:0] a, input logic [255:0] b);
    return a < b;
  endfunction

  assign mem_clk        = clk;
  assign mem_we         = 1'b0;
  assign mem_write_data = 32'h0;

  assign word_off   = 16'(NUM_NONCES) * {13'd0, c_cnt[2:0]};
  // Data arriving in step c belongs to the address issued in step c-1;
  // at c=8 the low bits wrap to 0, so this yields word 7.
  assign cap_word   = c_cnt[2:0] - 3'd1;
  assign last_nonce = (n_cnt == NONCE_W'(NUM_NONCES - 1));

  assign cand_hash  = {cand_w[0], cand_w[1], cand_w[2], cand_w[3],
                       cand_w[4], cand_w[5], cand_w[6], cand_w[7]};

  // Nonce 0 seeds the best; later nonces must be strictly smaller, so a
  // tie keeps the earlier (lower) index.
  always_comb begin
    take_cand     = (n_cnt == '0) || hash_lt(cand_hash, best_hash);
    best_hash_nxt = best_hash;
    best_idx_nxt  = best_idx;
    if (take_cand) begin
      best_hash_nxt = cand_hash;
      best_idx_nxt  = n_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = 16'h0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_READ;
      end
      S_READ: begin
        if (c_cnt < 4'd8) mem_addr = base_addr + word_off + 16'(n_cnt);
        if (c_cnt == 4'd8) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        state_nxt = last_nonce ? S_DONE : S_READ;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_cnt      <= '0;
      c_cnt      <= '0;
      base_addr  <= '0;
      target_q   <= '0;
      for (int i = 0; i < 8; i++) cand_w[i] <= '0;
      best_hash  <= '0;
      best_idx   <= '0;
      best_nonce <= '0;
      best_h0    <= '0;
      found      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_addr <= output_addr;
            target_q  <= target;
            n_cnt     <= '0;
            c_cnt     <= '0;
          end
        end
        S_READ: begin
          if (c_cnt != 4'd0) cand_w[cap_word] <= mem_read_data;
          c_cnt <= c_cnt + 4'd1;
        end
        S_COMPARE: begin
          best_hash <= best_hash_nxt;
          best_idx  <= best_idx_nxt;
          c_cnt     <= '0;
          if (last_nonce) begin
            // Results become visible together with done in the next cycle.
            best_nonce <= best_idx_nxt;
            best_h0    <= best_hash_nxt[255:224];
            found      <= (best_hash_nxt[255:224] < target_q);
          end else begin
            n_cnt <= n_cnt + NONCE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
